// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register-access controller.
// Protocol: command byte {rw, addr}, then auto-incrementing data bytes.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_STREAM,
    RD_ISSUE,
    RD_WAIT,
    RD_STREAM,
    DISCARD
  } state_e;

  localparam int         CMD_RW_BIT      = 7;
  localparam logic [7:0] STATUS_BYTE_DEF = 8'hA5;
  localparam logic       OP_RD           = 1'b1;
  localparam logic       OP_WR           = 1'b0;

  // Command bits between the address field and the rw bit must be zero.
  function automatic logic [7:0] hi_addr_mask(input int aw);
    return 8'h7F & ~8'((1 << aw) - 1);
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_cs_sync.sv
// Chip-select synchroniser with rise/fall pulses.
// All flops reset to the deselected (high) level.
module spi_cs_sync (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_CS_n,
  output logic o_Rise,
  output logic o_Fall
);

  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  // Next values: two-flop chain plus one delayed copy for edge detect.
  always_comb begin
    meta_d = i_CS_n;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Chain registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_Rise = sync_q & ~prev_q;
  assign o_Fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI byte-stream to register-file bridge.
// Writes stream into the register file; reads prefetch one byte ahead.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         ADDR_W      = 7,
  parameter int         RD_LATENCY  = 1,
  parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEF
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_SPI_CS_n,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  output logic [ADDR_W-1:0] o_Reg_Addr,
  output logic              o_Reg_Wr_En,
  output logic [7:0]        o_Reg_Wr_Data,
  output logic              o_Reg_Rd_En,
  input  logic [7:0]        i_Reg_Rd_Data,
  output logic              o_Busy,
  output logic              o_Err
);

  if (ADDR_W < 1 || ADDR_W > 7) begin : g_bad_aw
    $error("ADDR_W must be in 1..7");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_lat
    $error("RD_LATENCY must be 1 or 2");
  end

  localparam logic [7:0] BAD_MASK = hi_addr_mask(ADDR_W);
  localparam logic       LAT_LAST = 1'(RD_LATENCY - 1);

  logic cs_rise, cs_fall;

  spi_cs_sync u_cs_sync (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_CS_n (i_SPI_CS_n),
    .o_Rise (cs_rise),
    .o_Fall (cs_fall)
  );

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              rd_en_q, rd_en_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              cmd_bad;

  assign cmd_bad = |(i_RX_Byte & BAD_MASK);

  // Next-state and strobe logic; CS edges preempt the byte protocol.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    rd_en_d   = 1'b0;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    busy_d    = busy_q;
    err_d     = err_q;

    if (wr_en_q) begin
      addr_d = addr_q + 1'b1;
    end

    if (cs_rise) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      tx_dv_d   = 1'b1;
      tx_byte_d = STATUS_BYTE;
    end else if (cs_fall) begin
      state_d = CMD;
      busy_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        CMD: begin
          if (i_RX_DV) begin
            addr_d = i_RX_Byte[ADDR_W-1:0];
            if (cmd_bad) begin
              err_d   = 1'b1;
              state_d = DISCARD;
            end else if (i_RX_Byte[CMD_RW_BIT] == OP_RD) begin
              state_d = RD_ISSUE;
              rd_en_d = 1'b1;
            end else begin
              state_d = WR_STREAM;
            end
          end
        end
        WR_STREAM: begin
          if (i_RX_DV) begin
            wr_en_d   = 1'b1;
            wr_data_d = i_RX_Byte;
          end
        end
        RD_ISSUE: begin
          state_d = RD_WAIT;
          cnt_d   = 1'b0;
          if (i_RX_DV) begin
            err_d = 1'b1;
          end
        end
        RD_WAIT: begin
          if (i_RX_DV) begin
            err_d = 1'b1;
          end
          if (cnt_q == LAT_LAST) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = i_Reg_Rd_Data;
            addr_d    = addr_q + 1'b1;
            state_d   = RD_STREAM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RD_STREAM: begin
          if (i_RX_DV) begin
            state_d = RD_ISSUE;
            rd_en_d = 1'b1;
          end
        end
        DISCARD: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Controller registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'h00;
      rd_en_q   <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign o_TX_DV       = tx_dv_q;
  assign o_TX_Byte     = tx_byte_q;
  assign o_Reg_Addr    = addr_q;
  assign o_Reg_Wr_En   = wr_en_q;
  assign o_Reg_Wr_Data = wr_data_q;
  assign o_Reg_Rd_En   = rd_en_q;
  assign o_Busy        = busy_q;
  assign o_Err         = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: one 7-bit/lat-1 and
// one 4-bit/lat-2 instance, with small register-file models.
module tb_spi_reg_ctrl;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int excl_bad = 0;

  logic       cs_a, dv_a, txdv_a, we_a, re_a, busy_a, err_a;
  logic [7:0] rxb_a, txb_a, wd_a, rdd_a;
  logic [6:0] addr_a;

  logic       cs_b, dv_b, txdv_b, we_b, re_b, busy_b, err_b;
  logic [7:0] rxb_b, txb_b, wd_b, rdd_b, rdp_b;
  logic [3:0] addr_b;

  logic [7:0] mem_a [128];
  logic [7:0] mem_b [16];

  spi_reg_ctrl #(.ADDR_W(7), .RD_LATENCY(1)) dut_a (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_SPI_CS_n    (cs_a),
    .i_RX_DV       (dv_a),
    .i_RX_Byte     (rxb_a),
    .o_TX_DV       (txdv_a),
    .o_TX_Byte     (txb_a),
    .o_Reg_Addr    (addr_a),
    .o_Reg_Wr_En   (we_a),
    .o_Reg_Wr_Data (wd_a),
    .o_Reg_Rd_En   (re_a),
    .i_Reg_Rd_Data (rdd_a),
    .o_Busy        (busy_a),
    .o_Err         (err_a)
  );

  spi_reg_ctrl #(.ADDR_W(4), .RD_LATENCY(2)) dut_b (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_SPI_CS_n    (cs_b),
    .i_RX_DV       (dv_b),
    .i_RX_Byte     (rxb_b),
    .o_TX_DV       (txdv_b),
    .o_TX_Byte     (txb_b),
    .o_Reg_Addr    (addr_b),
    .o_Reg_Wr_En   (we_b),
    .o_Reg_Wr_Data (wd_b),
    .o_Reg_Rd_En   (re_b),
    .i_Reg_Rd_Data (rdd_b),
    .o_Busy        (busy_b),
    .o_Err         (err_b)
  );

  // Register-file read ports: 1 cycle for A, 2 cycles for B.
  always @(posedge clk) begin
    if (re_a) rdd_a <= mem_a[addr_a];
    if (re_b) rdp_b <= mem_b[addr_b];
    rdd_b <= rdp_b;
  end

  ev_t wr_a[$], rd_a[$], tx_a[$];
  ev_t wr_b[$], rd_b[$], tx_b[$];

  // Event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (we_a)   wr_a.push_back('{cyc, 8'(addr_a), wd_a});
      if (re_a)   rd_a.push_back('{cyc, 8'(addr_a), 8'h00});
      if (txdv_a) tx_a.push_back('{cyc, 8'h00, txb_a});
      if (we_b)   wr_b.push_back('{cyc, 8'(addr_b), wd_b});
      if (re_b)   rd_b.push_back('{cyc, 8'(addr_b), 8'h00});
      if (txdv_b) tx_b.push_back('{cyc, 8'h00, txb_b});
      if ((we_a && re_a) || (we_b && re_b)) excl_bad <= excl_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic ev_t at(input ev_t q[$], input int i);
    if (i < q.size()) return q[i];
    return '{-1, 8'h00, 8'h00};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx(input bit b, input logic [7:0] v, output int c);
    c = cyc;
    if (b) begin
      dv_b  = 1'b1;
      rxb_b = v;
    end else begin
      dv_a  = 1'b1;
      rxb_a = v;
    end
    tick(1);
    dv_a = 1'b0;
    dv_b = 1'b0;
  endtask

  task automatic clear_q();
    wr_a.delete(); rd_a.delete(); tx_a.delete();
    wr_b.delete(); rd_b.delete(); tx_b.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int         c, d, c0, c1, c2;
  int         cw[3];
  logic [7:0] wdat[3];
  logic [7:0] rexp[3];

  initial begin
    wdat = '{8'h11, 8'h22, 8'h33};
    rexp = '{8'hDE, 8'hAD, 8'hBE};
    for (int i = 0; i < 128; i++) mem_a[i] = 8'(i);
    for (int i = 0; i < 16; i++)  mem_b[i] = 8'(i + 8'h40);
    mem_a[16] = 8'hDE; mem_a[17] = 8'hAD; mem_a[18] = 8'hBE;
    mem_b[3]  = 8'h3C;
    rst = 1'b1;
    cs_a = 1'b1; dv_a = 1'b0; rxb_a = 8'h00;
    cs_b = 1'b1; dv_b = 1'b0; rxb_b = 8'h00;

    // reset values
    tick(3);
    check("rst_out_a", {txdv_a, txb_a, addr_a, we_a, wd_a, re_a, busy_a, err_a}, 0);
    check("rst_out_b", {txdv_b, txb_b, addr_b, we_b, wd_b, re_b, busy_b, err_b}, 0);
    rst = 1'b0;
    tick(2);
    clear_q();

    // write burst at 5,6,7
    cs_a = 1'b0;
    tick(4);
    check("wr_busy_on", busy_a, 1);
    rx(0, 8'h05, d);
    tick(2);
    for (int i = 0; i < 3; i++) begin
      rx(0, wdat[i], cw[i]);
      tick(2);
    end
    cs_a = 1'b1;
    tick(5);
    check("wr_count", wr_a.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr%0d_addr", i), at(wr_a, i).a, 5 + i);
      check($sformatf("wr%0d_data", i), at(wr_a, i).d, wdat[i]);
      check($sformatf("wr%0d_cyc", i), at(wr_a, i).cyc, cw[i] + 1);
    end
    check("wr_rd_none", rd_a.size(), 0);
    check("wr_tx_count", tx_a.size(), 1);
    check("wr_tx_pre", at(tx_a, 0).d, 8'hA5);
    check("wr_busy_off", busy_a, 0);
    check("wr_err", err_a, 0);
    clear_q();

    // read burst from 0x10
    cs_a = 1'b0;
    tick(4);
    rx(0, 8'h90, c0);
    tick(4);
    rx(0, 8'h00, c1);
    tick(4);
    rx(0, 8'h00, c2);
    tick(4);
    cs_a = 1'b1;
    tick(5);
    cw = '{c0, c1, c2};
    check("rd_count", rd_a.size(), 3);
    check("rd_tx_count", tx_a.size(), 4);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rd%0d_addr", i), at(rd_a, i).a, 8'h10 + i);
      check($sformatf("rd%0d_cyc", i), at(rd_a, i).cyc, cw[i] + 1);
      check($sformatf("rd%0d_tx", i), at(tx_a, i).d, rexp[i]);
      check($sformatf("rd%0d_txcyc", i), at(tx_a, i).cyc, cw[i] + 3);
    end
    check("rd_tx_pre", at(tx_a, 3).d, 8'hA5);
    check("rd_wr_none", wr_a.size(), 0);
    clear_q();

    // address wrap 0x7F -> 0x00
    cs_a = 1'b0;
    tick(4);
    rx(0, 8'h7F, d);
    tick(2);
    rx(0, 8'hAA, d);
    tick(2);
    rx(0, 8'hBB, d);
    tick(2);
    cs_a = 1'b1;
    tick(5);
    check("wrap_count", wr_a.size(), 2);
    check("wrap0_addr", at(wr_a, 0).a, 8'h7F);
    check("wrap0_data", at(wr_a, 0).d, 8'hAA);
    check("wrap1_addr", at(wr_a, 1).a, 8'h00);
    check("wrap1_data", at(wr_a, 1).d, 8'hBB);
    check("wrap_err", err_a, 0);
    clear_q();

    // bad command on 4-bit instance, then a good one
    cs_b = 1'b0;
    tick(4);
    rx(1, 8'h20, d);
    tick(2);
    check("bad_err", err_b, 1);
    rx(1, 8'h55, d);
    tick(3);
    check("bad_no_strobe", wr_b.size() + rd_b.size(), 0);
    cs_b = 1'b1;
    tick(5);
    cs_b = 1'b0;
    tick(4);
    rx(1, 8'h02, d);
    tick(2);
    rx(1, 8'h66, c);
    tick(2);
    cs_b = 1'b1;
    tick(5);
    check("good_count", wr_b.size(), 1);
    check("good_addr", at(wr_b, 0).a, 8'h02);
    check("good_data", at(wr_b, 0).d, 8'h66);
    check("good_cyc", at(wr_b, 0).cyc, c + 1);
    check("bad_sticky", err_b, 1);
    check("bad_tx_count", tx_b.size(), 2);
    clear_q();

    // CS rises while the read is waiting on the register file
    cs_b = 1'b0;
    tick(4);
    rx(1, 8'h83, c0);
    cs_b = 1'b1;
    tick(8);
    check("abort_rd_count", rd_b.size(), 1);
    check("abort_rd_addr", at(rd_b, 0).a, 8'h03);
    check("abort_rd_cyc", at(rd_b, 0).cyc, c0 + 1);
    check("abort_tx_count", tx_b.size(), 1);
    check("abort_tx_byte", at(tx_b, 0).d, 8'hA5);
    check("abort_tx_cyc", at(tx_b, 0).cyc, c0 + 4);
    check("abort_busy", busy_b, 0);
    clear_q();

    // overrun during RD_WAIT
    cs_a = 1'b0;
    tick(4);
    rx(0, 8'h90, c0);
    tick(1);
    rx(0, 8'h77, d);
    tick(4);
    check("ovr_err", err_a, 1);
    check("ovr_rd_count", rd_a.size(), 1);
    check("ovr_tx_count", tx_a.size(), 1);
    check("ovr_tx_byte", at(tx_a, 0).d, 8'hDE);
    check("ovr_tx_cyc", at(tx_a, 0).cyc, c0 + 3);
    cs_a = 1'b1;
    tick(5);
    clear_q();

    // reset in the middle of a write burst
    cs_a = 1'b0;
    tick(4);
    rx(0, 8'h04, d);
    tick(2);
    rx(0, 8'h12, d);
    check("mid_wr_strobe", we_a, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_out", {txdv_a, txb_a, addr_a, we_a, wd_a, re_a, busy_a, err_a}, 0);
    clear_q();
    tick(4);
    rx(0, 8'h21, d);
    tick(4);
    check("post_rst_wr", wr_a.size(), 0);
    check("post_rst_rd", rd_a.size(), 0);
    cs_a = 1'b1;
    tick(5);

    check("excl", excl_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
